// File: rtl/cs_sequencer.sv
// cs_sequencer: registered one-hot chip-select sequencer with req/ready,
// fixed hold and turnaround timing, abort and optional range check.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, addr       request and target device index (SEL_W bits)
//   ready           high when a request can be accepted (IDLE)
//   abort           ends an active select early
//   cs              registered one-hot chip selects (NUM_OUT bits)
//   busy            high while not IDLE
//   done            one-cycle pulse when a select ends
//   err             one-cycle pulse on out-of-range address
//
// Optional feature macro: CS_RANGE_CHK_EN (out-of-range requests are
// rejected with err instead of running a cs=0 select sequence).
module cs_sequencer #(
   parameter int SEL_W    = 3,
   parameter int NUM_OUT  = 8,
   parameter int HOLD     = 2,
   parameter int TURN_CYC = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   input  logic [SEL_W-1:0]   addr,
   output logic               ready,
   input  logic               abort,
   output logic [NUM_OUT-1:0] cs,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int MAXC = (HOLD > TURN_CYC) ? HOLD : TURN_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_TURN   = 2'd2;

   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_HOLD = CW'(HOLD);
   localparam logic [CW-1:0] C_TURN = CW'(TURN_CYC);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [NUM_OUT-1:0] dec;
   logic               oor;

   // Addresses beyond NUM_OUT decode to all-zero.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (int'(addr) == i) dec[i] = 1'b1;
      end
   end

`ifdef CS_RANGE_CHK_EN
   assign oor = (int'(addr) >= NUM_OUT);
`else
   assign oor = 1'b0;
`endif

   assign ready = (state == S_IDLE);
   assign busy  = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         cs    <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (oor) begin
                     err <= 1'b1;
                  end else begin
                     cs    <= dec;
                     cnt   <= C_HOLD;
                     state <= S_ACTIVE;
                  end
               end
            end
            S_ACTIVE: begin
               // Abort on the final hold cycle is just a normal end.
               if (abort || cnt == C_ONE) begin
                  cs   <= '0;
                  done <= 1'b1;
                  if (TURN_CYC == 0) begin
                     state <= S_IDLE;
                     cnt   <= '0;
                  end else begin
                     state <= S_TURN;
                     cnt   <= C_TURN;
                  end
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
            S_TURN: begin
               if (cnt <= C_ONE) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               cs    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: scoreboard bench for cs_sequencer across four
// parameter sets (defaults, TURN_CYC=0, HOLD=5, NUM_OUT=6).
module tb_cs_sequencer;

   typedef struct {
      int       inst;
      logic [7:0] cs;
      logic     done;
      logic     busy;
      logic     ready;
      logic     err;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       req0, req1, req2, req3;
   logic [2:0] addr0, addr1, addr2, addr3;
   logic       abt0, abt1, abt2, abt3;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic       bsy0, bsy1, bsy2, bsy3;
   logic       dn0, dn1, dn2, dn3;
   logic       er0, er1, er2, er3;
   logic [7:0] cs0, cs1, cs2;
   logic [5:0] cs3;

   cs_sequencer u0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr0),
      .ready(rdy0), .abort(abt0), .cs(cs0), .busy(bsy0),
      .done(dn0), .err(er0)
   );

   cs_sequencer #(.TURN_CYC(0)) u1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .addr(addr1),
      .ready(rdy1), .abort(abt1), .cs(cs1), .busy(bsy1),
      .done(dn1), .err(er1)
   );

   cs_sequencer #(.HOLD(5)) u2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .addr(addr2),
      .ready(rdy2), .abort(abt2), .cs(cs2), .busy(bsy2),
      .done(dn2), .err(er2)
   );

   cs_sequencer #(.NUM_OUT(6)) u3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .addr(addr3),
      .ready(rdy3), .abort(abt3), .cs(cs3), .busy(bsy3),
      .done(dn3), .err(er3)
   );

   task automatic check(input string tag, input int obs,
                        input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic observe(input int inst, output exp_t o);
      o.inst = inst;
      case (inst)
         0: begin
            o.cs = cs0; o.done = dn0; o.busy = bsy0;
            o.ready = rdy0; o.err = er0;
         end
         1: begin
            o.cs = cs1; o.done = dn1; o.busy = bsy1;
            o.ready = rdy1; o.err = er1;
         end
         2: begin
            o.cs = cs2; o.done = dn2; o.busy = bsy2;
            o.ready = rdy2; o.err = er2;
         end
         default: begin
            o.cs = {2'b00, cs3}; o.done = dn3; o.busy = bsy3;
            o.ready = rdy3; o.err = er3;
         end
      endcase
   endtask

   task automatic compare(input exp_t e);
      exp_t o;
      string s;
      observe(e.inst, o);
      s = $sformatf("u%0d", e.inst);
      check({s, ".cs"}, int'(o.cs), int'(e.cs));
      check({s, ".done"}, int'(o.done), int'(e.done));
      check({s, ".busy"}, int'(o.busy), int'(e.busy));
      check({s, ".ready"}, int'(o.ready), int'(e.ready));
      check({s, ".err"}, int'(o.err), int'(e.err));
      check({s, ".onehot0"}, int'($onehot0(o.cs)), 1);
   endtask

   task automatic push_rec(input int inst, input logic [7:0] c,
                           input logic d, input logic b,
                           input logic r, input logic e);
      exp_t x;
      x.inst = inst; x.cs = c; x.done = d;
      x.busy = b; x.ready = r; x.err = e;
      q.push_back(x);
   endtask

   // Expected cycles after an accept edge: HOLD active cycles,
   // done cycle, remaining turnaround, then IDLE.
   task automatic push_sel(input int inst, input logic [7:0] c,
                           input int hold, input int turn);
      for (int i = 0; i < hold; i++) push_rec(inst, c, 0, 1, 0, 0);
      if (turn == 0) begin
         push_rec(inst, 8'h00, 1, 0, 1, 0);
      end else begin
         push_rec(inst, 8'h00, 1, 1, 0, 0);
         for (int i = 1; i < turn; i++)
            push_rec(inst, 8'h00, 0, 1, 0, 0);
         push_rec(inst, 8'h00, 0, 0, 1, 0);
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         compare(e);
      end
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 1'b0;
      {req0, req1, req2, req3} = '0;
      {abt0, abt1, abt2, abt3} = '0;
      {addr0, addr1, addr2, addr3} = '0;
      #3;
      check("rst.cs", int'(cs0), 0);
      check("rst.busy", int'(bsy0), 0);
      check("rst.ready", int'(rdy0), 1);
      check("rst.done", int'(dn0), 0);
      check("rst.err", int'(er3), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Default timing, addr=3.
      req0 = 1; addr0 = 3'd3;
      push_sel(0, 8'h08, 2, 1);
      step();
      req0 = 0;
      step_n(3);

      // Sweep every address.
      for (int a = 0; a < 8; a++) begin
         logic [7:0] m;
         m = 8'h01 << a;
         req0 = 1; addr0 = 3'(a);
         push_sel(0, m, 2, 1);
         step();
         req0 = 0;
         step_n(3);
      end

      // Back-to-back with req held, TURN_CYC=0.
      req1 = 1; addr1 = 3'd0;
      push_sel(1, 8'h01, 2, 0);
      push_sel(1, 8'h80, 2, 0);
      step();
      addr1 = 3'd7;
      step_n(3);
      req1 = 0;
      step_n(2);

      // Abort in the second ACTIVE cycle, HOLD=5.
      req2 = 1; addr2 = 3'd5;
      push_sel(2, 8'h20, 2, 1);
      push_rec(2, 8'h00, 0, 0, 1, 0);
      step();
      req2 = 0;
      step();
      abt2 = 1;
      step();
      abt2 = 0;
      step_n(2);

      // Abort on the final hold cycle: single done, normal timing.
      req0 = 1; addr0 = 3'd1;
      push_sel(0, 8'h02, 2, 1);
      push_rec(0, 8'h00, 0, 0, 1, 0);
      step();
      req0 = 0;
      step();
      abt0 = 1;
      step();
      abt0 = 0;
      step_n(2);

      // Out-of-range address with NUM_OUT=6.
      req3 = 1; addr3 = 3'd6;
`ifdef CS_RANGE_CHK_EN
      push_rec(3, 8'h00, 0, 0, 1, 1);
      push_sel(3, 8'h02, 2, 1);
      step();
      addr3 = 3'd1;
      step();
      req3 = 0;
      step_n(3);
`else
      push_sel(3, 8'h00, 2, 1);
      step();
      req3 = 0;
      step_n(3);
`endif

      // Reset during ACTIVE.
      req0 = 1; addr0 = 3'd2;
      push_rec(0, 8'h04, 0, 1, 0, 0);
      step();
      req0 = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.cs", int'(cs0), 0);
      check("midrst.busy", int'(bsy0), 0);
      check("midrst.done", int'(dn0), 0);
      check("midrst.ready", int'(rdy0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         push_rec(0, 8'h00, 0, 0, 1, 0);
      step_n(4);

      check("sb.drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
